uv_div_issue: RTL and testbench
===============================

Name: uv_div_issue

Overview:
- Initiator-side controller between the execution pipeline and the multi-cycle divider.
- Accepts one DIV/DIVU/REM/REMU micro-op at a time and issues it on the divider req channel under the divider's ready rule.
- Captures the divider response, which has no backpressure, and holds it for a ready/valid writeback port.
- Handles pipeline flush by draining the in-flight divide.
- Keeps a one-entry result cache so a repeated identical op completes without using the divider.

Parameters:
- DIV_DW, 32, operand/result width; must match the divider.
- RD_AW, 5, destination register index width.
- CACHE_EN, 1, 1 = last-result reuse enabled; 0 = always issue.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- exu_vld  input  1  micro-op valid
- exu_rdy  output  1  controller can accept a micro-op
- exu_sgn  input  1  signed op
- exu_rem  input  1  1 = remainder, 0 = quotient
- exu_opa  input  DIV_DW  dividend
- exu_opb  input  DIV_DW  divisor
- exu_rd  input  RD_AW  destination register
- exu_flush  input  1  kill current op
- div_req_rdy  input  1  divider idle
- div_req_vld  output  1  divider request
- div_req_sgn  output  1  to divider
- div_req_rem  output  1  to divider
- div_req_opa  output  DIV_DW  to divider
- div_req_opb  output  DIV_DW  to divider
- div_rsp_vld  input  1  divider response, single-cycle pulse, may be combinational with req
- div_rsp_res  input  DIV_DW  divider result
- wb_vld  output  1  writeback valid
- wb_rdy  input  1  writeback accepted
- wb_rd  output  RD_AW  writeback register
- wb_res  output  DIV_DW  writeback data

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, except exu_rdy = 1 (combinational from IDLE).
  - Operand, result and cache registers 0; cache_vld = 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. Encoded in 3 bits, registered.
- exu_rdy = (state == IDLE) & ~exu_flush. An op is accepted on exu_vld & exu_rdy; sgn, rem, opa, opb and rd are latched that edge.
- IDLE, on accept:
  - Cache hit (CACHE_EN & cache_vld & key equal on {sgn, rem, opa, opb}): load the cached result and go to DONE. Total latency 1 cycle to wb_vld.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_req_vld = div_req_rdy & ~exu_flush. Never assert req_vld while div_req_rdy = 0; the divider would corrupt its operation.
  - div_req_* data are driven from the latched registers in every state.
  - If req_vld and div_rsp_vld occur in the same cycle (divide-by-zero path), capture the result and go to DONE.
  - Else if req_vld, go to WAIT.
  - Else stay in ISSUE.
- WAIT: on div_rsp_vld, capture div_rsp_res and go to DONE.
- DONE:
  - wb_vld = ~exu_flush; wb_rd and wb_res come from registers.
  - On wb_vld & wb_rdy, go to IDLE.
  - Data stay stable while wb_vld = 1 and wb_rdy = 0.
- Capture:
  - Result register updated.
  - If CACHE_EN, the cache key and result are updated and cache_vld is set.
  - Division is pure, so the cache is never invalidated except by reset.
- Flush (highest priority over all other events in the same cycle):
  - IDLE: nothing accepted.
  - ISSUE: no request issued; go to IDLE.
  - WAIT: go to DRAIN.
  - DONE: go to IDLE; wb_vld is forced 0 that cycle even if wb_rdy = 1.
  - DRAIN: stay.
- DRAIN:
  - On div_rsp_vld, discard the result (no cache update) and go to IDLE.
  - exu_rdy = 0 in DRAIN, so no new request can collide with the busy divider.
- div_rsp_vld in IDLE or DONE is ignored; the simulation assertion flags it as a protocol error.
- Worst-case latency from accept to wb_vld: 1 (ISSUE) + divider latency (DIV_DW + 2) cycles.
- Reset asserted mid-operation returns to IDLE immediately. The divider shares rst_n, so no drain is needed.

Decomposition:
- Shared package uv_div_pkg:
  - State encoding localparams (IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3, DRAIN = 4).
  - DIV_DW default.
  - Key width constant (2 + 2*DIV_DW).
- One natural sub-module, uv_div_cache: one-entry key/result store with compare (hit output, write port). It is tied off when CACHE_EN = 0.

Test Plan:
- Unsigned DIVU opa = 100, opb = 7 (wb_rdy = 1) -> one div_req_vld pulse; wb_res = 14; wb_vld ≤ DIV_DW + 4 cycles after accept; exu_rdy is 0 until writeback.
- Signed REM opa = -7 (0xFFFFFFF9), opb = 2 -> wb_res = 0xFFFFFFFF. Then repeat the identical op -> cache hit, wb_vld the cycle after accept, no div_req_vld.
- DIVU opb = 0 -> req and rsp in the same cycle, straight to DONE, wb_res = 0xFFFFFFFF. REMU opa = 5, opb = 0 -> wb_res = 5.
- Flush 3 cycles after issue of 100/7 -> DRAIN; exu_vld held high is refused until the divider response; no wb_vld; the next op 9/3 returns 3.
- wb_rdy held 0 for 10 cycles in DONE -> wb_vld, wb_rd and wb_res stable. Flush in DONE with wb_rdy = 1 -> wb_vld = 0, return to IDLE.
- div_req_rdy forced 0 for 5 cycles in ISSUE -> div_req_vld stays 0; issued on the first ready cycle. rst_n pulsed in WAIT -> all outputs at reset values, exu_rdy = 1 once rst_n is deasserted.

Source files
------------

// File: rtl/uv_div_pkg.sv
// uv_div_pkg: shared types and constants for the divider issue controller.
//   - div_state_e : controller FSM encoding (3 bits)
//   - DIV_DW_DEF  : default operand/result width
//   - key_w()     : width of the result-cache key {sgn, rem, opa, opb}
package uv_div_pkg;

    localparam int DIV_DW_DEF = 32;
    localparam int RD_AW_DEF  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_e;

    function automatic int key_w(input int dw);
        return 2 + 2 * dw;
    endfunction

    localparam int KEY_W_DEF = 2 + 2 * DIV_DW_DEF;

endpackage

// File: rtl/uv_div_cache.sv
// uv_div_cache: one-entry last-result store for the divide controller.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       write the entry (key + result) and mark it valid
//   wr_key      key of the op whose result is being written
//   wr_res      result to store
//   lk_key      key of the op being looked up
//   hit         entry valid and key matches lk_key
//   hit_res     stored result (meaningful when hit = 1)
module uv_div_cache
    import uv_div_pkg::*;
#(
    parameter int DIV_DW = DIV_DW_DEF,
    parameter int KEY_W  = KEY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [DIV_DW-1:0] wr_res,
    input  logic [KEY_W-1:0]  lk_key,
    output logic              hit,
    output logic [DIV_DW-1:0] hit_res
);

    logic              vld_q, vld_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DIV_DW-1:0] res_q, res_d;

    // Division is pure, so an entry is never invalidated once written.
    always_comb begin
        vld_d = vld_q;
        key_d = key_q;
        res_d = res_q;
        if (wr_en) begin
            vld_d = 1'b1;
            key_d = wr_key;
            res_d = wr_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            key_q <= '0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            key_q <= key_d;
            res_q <= res_d;
        end
    end

    assign hit     = vld_q && (key_q == lk_key);
    assign hit_res = res_q;

endmodule

// File: rtl/uv_div_issue.sv
// uv_div_issue: initiator-side controller between the execution pipeline and
// the multi-cycle divider. Accepts one divide/remainder micro-op at a time,
// issues it to the divider, holds the result for a ready/valid writeback
// port, drains the divider on flush and reuses the last result when the same
// op repeats.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   exu_vld/exu_rdy             micro-op handshake
//   exu_sgn/rem/opa/opb/rd      micro-op fields, latched on accept
//   exu_flush                   kill the current op
//   div_req_rdy/div_req_vld     divider request handshake (rdy = divider idle)
//   div_req_sgn/rem/opa/opb     divider request data (from latched registers)
//   div_rsp_vld/div_rsp_res     divider response pulse, no backpressure
//   wb_vld/wb_rdy/wb_rd/wb_res  writeback handshake and data
module uv_div_issue
    import uv_div_pkg::*;
#(
    parameter int DIV_DW   = DIV_DW_DEF,
    parameter int RD_AW    = RD_AW_DEF,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exu_vld,
    output logic              exu_rdy,
    input  logic              exu_sgn,
    input  logic              exu_rem,
    input  logic [DIV_DW-1:0] exu_opa,
    input  logic [DIV_DW-1:0] exu_opb,
    input  logic [RD_AW-1:0]  exu_rd,
    input  logic              exu_flush,
    input  logic              div_req_rdy,
    output logic              div_req_vld,
    output logic              div_req_sgn,
    output logic              div_req_rem,
    output logic [DIV_DW-1:0] div_req_opa,
    output logic [DIV_DW-1:0] div_req_opb,
    input  logic              div_rsp_vld,
    input  logic [DIV_DW-1:0] div_rsp_res,
    output logic              wb_vld,
    input  logic              wb_rdy,
    output logic [RD_AW-1:0]  wb_rd,
    output logic [DIV_DW-1:0] wb_res
);

    localparam int KW = key_w(DIV_DW);

    div_state_e        state_q, state_d;
    logic              sgn_q, sgn_d;
    logic              rem_q, rem_d;
    logic [DIV_DW-1:0] opa_q, opa_d;
    logic [DIV_DW-1:0] opb_q, opb_d;
    logic [RD_AW-1:0]  rd_q, rd_d;
    logic [DIV_DW-1:0] res_q, res_d;

    logic              accept;
    logic              cache_wr;
    logic              cache_hit;
    logic [DIV_DW-1:0] cache_res;
    logic [KW-1:0]     lk_key;
    logic [KW-1:0]     wr_key;

    // Lookup uses the incoming op so a hit can skip the ISSUE state; the write
    // key is the latched op whose result is being captured.
    assign lk_key = {exu_sgn, exu_rem, exu_opa, exu_opb};
    assign wr_key = {sgn_q, rem_q, opa_q, opb_q};

    generate
        if (CACHE_EN) begin : g_cache
            uv_div_cache #(
                .DIV_DW (DIV_DW),
                .KEY_W  (KW)
            ) u_cache (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (cache_wr),
                .wr_key  (wr_key),
                .wr_res  (res_d),
                .lk_key  (lk_key),
                .hit     (cache_hit),
                .hit_res (cache_res)
            );
        end else begin : g_no_cache
            assign cache_hit = 1'b0;
            assign cache_res = '0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        rem_d    = rem_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        res_d    = res_q;
        cache_wr = 1'b0;

        exu_rdy     = (state_q == ST_IDLE) && !exu_flush;
        accept      = exu_vld && exu_rdy;
        // Gated by div_req_rdy: a request to a busy divider corrupts it.
        div_req_vld = (state_q == ST_ISSUE) && div_req_rdy && !exu_flush;
        wb_vld      = (state_q == ST_DONE) && !exu_flush;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sgn_d = exu_sgn;
                    rem_d = exu_rem;
                    opa_d = exu_opa;
                    opb_d = exu_opb;
                    rd_d  = exu_rd;
                    if (cache_hit) begin
                        res_d   = cache_res;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (exu_flush) begin
                    state_d = ST_IDLE;
                end else if (div_req_vld) begin
                    // Divide-by-zero answers in the same cycle as the request.
                    if (div_rsp_vld) begin
                        res_d    = div_rsp_res;
                        cache_wr = CACHE_EN;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (exu_flush) begin
                    // A response landing on the flush cycle is already the
                    // drain event; waiting in DRAIN for another would hang.
                    state_d = div_rsp_vld ? ST_IDLE : ST_DRAIN;
                end else if (div_rsp_vld) begin
                    res_d    = div_rsp_res;
                    cache_wr = CACHE_EN;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (exu_flush || wb_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Result of the killed op is dropped, cache left untouched.
                if (div_rsp_vld) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sgn_q   <= 1'b0;
            rem_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    assign div_req_sgn = sgn_q;
    assign div_req_rem = rem_q;
    assign div_req_opa = opa_q;
    assign div_req_opb = opb_q;
    assign wb_rd       = rd_q;
    assign wb_res      = res_q;

    // The divider only answers requests we made; a response while idle or
    // holding a result means the two sides disagree about what is in flight.
    a_rsp_unexpected: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(div_rsp_vld && (state_q == ST_IDLE || state_q == ST_DONE))
    );

endmodule

// File: tb/tb_uv_div_issue.sv
module tb_uv_div_issue;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = DW + 2;
    localparam int MAX_LAT = DW + 4;

    logic          clk, rst_n;
    logic          exu_vld, exu_rdy, exu_sgn, exu_rem, exu_flush;
    logic [DW-1:0] exu_opa, exu_opb;
    logic [AW-1:0] exu_rd;
    logic          div_req_rdy, div_req_vld, div_req_sgn, div_req_rem;
    logic [DW-1:0] div_req_opa, div_req_opb;
    logic          div_rsp_vld;
    logic [DW-1:0] div_rsp_res;
    logic          wb_vld, wb_rdy;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_res;

    uv_div_issue #(.DIV_DW(DW), .RD_AW(AW), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_vld(exu_vld), .exu_rdy(exu_rdy), .exu_sgn(exu_sgn), .exu_rem(exu_rem),
        .exu_opa(exu_opa), .exu_opb(exu_opb), .exu_rd(exu_rd), .exu_flush(exu_flush),
        .div_req_rdy(div_req_rdy), .div_req_vld(div_req_vld), .div_req_sgn(div_req_sgn),
        .div_req_rem(div_req_rem), .div_req_opa(div_req_opa), .div_req_opb(div_req_opb),
        .div_rsp_vld(div_rsp_vld), .div_rsp_res(div_rsp_res),
        .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_res(wb_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider model ----------------
    logic          force_off;
    logic          div_busy;
    int            div_cnt;
    logic [DW-1:0] m_res;
    int            req_cnt;
    logic          zero_div;

    function automatic logic [DW-1:0] ref_div(input logic sgn, input logic rem,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (sgn) return rem ? DW'($signed(a) % $signed(b)) : DW'($signed(a) / $signed(b));
        return rem ? a % b : a / b;
    endfunction

    assign div_req_rdy = !div_busy && !force_off;
    assign zero_div    = div_req_vld && (div_req_opb == '0);
    assign div_rsp_vld = zero_div || (div_busy && div_cnt == 0);
    assign div_rsp_res = zero_div ? (div_req_rem ? div_req_opa : '1) : m_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0;
            div_cnt  <= 0;
            m_res    <= '0;
            req_cnt  <= 0;
        end else begin
            if (div_req_vld) req_cnt <= req_cnt + 1;
            if (div_busy) begin
                if (div_cnt == 0) div_busy <= 1'b0;
                else              div_cnt  <= div_cnt - 1;
            end else if (div_req_vld && div_req_opb != '0) begin
                div_busy <= 1'b1;
                div_cnt  <= LAT - 1;
                m_res    <= ref_div(div_req_sgn, div_req_rem, div_req_opa, div_req_opb);
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic          sgn;
        logic          rem;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [AW-1:0] rd;
        logic [DW-1:0] res;
        bit            hit;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+DW-1:0] sb_q[$];

    task automatic expect_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        exu_sgn = v.sgn;
        exu_rem = v.rem;
        exu_opa = v.opa;
        exu_opb = v.opb;
        exu_rd  = v.rd;
        exu_vld = 1'b1;
    endtask

    // Waits for exu_rdy with exu_vld held, then takes the accept edge.
    task automatic accept_op(input string nm);
        int n = 0;
        while (!exu_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        expect_eq({nm, "_accept_timeout"}, 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        exu_vld = 1'b0;
    endtask

    // Called #1 after the accept edge; lat = cycles from accept to wb_vld.
    task automatic wait_wb(input string nm, output int lat);
        bit rdy_bad = 1'b0;
        lat = 1;
        while (!wb_vld && lat < 200) begin
            if (exu_rdy) rdy_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (exu_rdy) rdy_bad = 1'b1;
        expect_eq({nm, "_wb_timeout"}, 64'(lat < 200), 64'd1);
        expect_eq({nm, "_exu_rdy_busy"}, 64'(rdy_bad), 64'd0);
    endtask

    task automatic pop_check(input string nm);
        logic [AW+DW-1:0] e;
        expect_eq({nm, "_wb_handshake"}, 64'(wb_vld && wb_rdy), 64'd1);
        if (sb_q.size() == 0) begin
            expect_eq({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            expect_eq({nm, "_wb_rd"},  64'(wb_rd),  64'(e[AW+DW-1:DW]));
            expect_eq({nm, "_wb_res"}, 64'(wb_res), 64'(e[DW-1:0]));
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        int r0;
        drive_op(v);
        r0 = req_cnt;
        accept_op(nm);
        sb_q.push_back({v.rd, v.res});
        wait_wb(nm, lat);
        if (v.hit) expect_eq({nm, "_hit_latency"}, 64'(lat), 64'd1);
        else       expect_eq({nm, "_latency_bound"}, 64'(lat <= MAX_LAT), 64'd1);
        pop_check(nm);
        @(posedge clk); #1;
        expect_eq({nm, "_req_pulses"}, 64'(req_cnt - r0), v.hit ? 64'd0 : 64'd1);
    endtask

    vec_t tbl[11];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   lat;
        int   n;
        int   r0;
        logic [AW-1:0] s_rd;
        logic [DW-1:0] s_res;
        bit   saw_wb;

        //            sgn   rem   opa            opb            rd     res            hit
        tbl[0]  = '{1'b0, 1'b0, 32'd100,       32'd7,         5'd1,  32'd14,        1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFF, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'd20,        32'd0,         5'd4,  32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'd5,         32'd0,         5'd5,  32'd5,         1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7,         5'd6,  32'hFFFF_FFF2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'd100,       32'd7,         5'd7,  32'd2,         1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'd100,       32'd7,         5'd8,  32'd14,        1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'd100,       32'd7,         5'd9,  32'd14,        1'b1};
        tbl[9]  = '{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'd100,       32'd7,         5'd11, 32'd14,        1'b0};

        rst_n = 1'b0; exu_vld = 1'b0; exu_sgn = 1'b0; exu_rem = 1'b0;
        exu_opa = '0; exu_opb = '0; exu_rd = '0; exu_flush = 1'b0;
        wb_rdy = 1'b1; force_off = 1'b0;

        // reset state
        repeat (2) @(posedge clk); #1;
        expect_eq("rst_exu_rdy", 64'(exu_rdy), 64'd1);
        expect_eq("rst_req_vld", 64'(div_req_vld), 64'd0);
        expect_eq("rst_wb_vld",  64'(wb_vld), 64'd0);
        expect_eq("rst_wb_res",  64'(wb_res), 64'd0);
        expect_eq("rst_wb_rd",   64'(wb_rd), 64'd0);
        expect_eq("rst_req_opa", 64'(div_req_opa), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven ops
        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // writeback stall: data held stable for 10 cycles
        wb_rdy = 1'b0;
        v = '{1'b0, 1'b0, 32'd81, 32'd9, 5'd12, 32'd9, 1'b0};
        drive_op(v);
        accept_op("stall");
        sb_q.push_back({v.rd, v.res});
        wait_wb("stall", lat);
        s_rd = wb_rd; s_res = wb_res;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            expect_eq("stall_wb_vld", 64'(wb_vld), 64'd1);
            expect_eq("stall_wb_rd",  64'(wb_rd),  64'(s_rd));
            expect_eq("stall_wb_res", 64'(wb_res), 64'(s_res));
        end
        wb_rdy = 1'b1; #1;
        pop_check("stall");
        @(posedge clk); #1;

        // flush in DONE with wb_rdy = 1 (81/9 repeat is a cache hit)
        wb_rdy = 1'b0;
        v = '{1'b0, 1'b0, 32'd81, 32'd9, 5'd13, 32'd9, 1'b1};
        drive_op(v);
        accept_op("flush_done");
        expect_eq("flush_done_wb_vld_pre", 64'(wb_vld), 64'd1);
        exu_flush = 1'b1; wb_rdy = 1'b1; #1;
        expect_eq("flush_done_wb_vld", 64'(wb_vld), 64'd0);
        @(posedge clk); #1;
        exu_flush = 1'b0; #1;
        expect_eq("flush_done_wb_vld_post", 64'(wb_vld), 64'd0);
        expect_eq("flush_done_idle", 64'(exu_rdy), 64'd1);

        // divider not ready for 5 cycles in ISSUE
        force_off = 1'b1;
        v = '{1'b0, 1'b0, 32'd1000, 32'd10, 5'd14, 32'd100, 1'b0};
        drive_op(v);
        r0 = req_cnt;
        accept_op("req_rdy");
        sb_q.push_back({v.rd, v.res});
        for (int k = 0; k < 5; k++) begin
            expect_eq("req_rdy_held", 64'(div_req_vld), 64'd0);
            @(posedge clk); #1;
        end
        force_off = 1'b0; #1;
        expect_eq("req_rdy_first", 64'(div_req_vld), 64'd1);
        wait_wb("req_rdy", lat);
        pop_check("req_rdy");
        @(posedge clk); #1;
        expect_eq("req_rdy_pulses", 64'(req_cnt - r0), 64'd1);

        // reset asserted while waiting on the divider
        v = '{1'b0, 1'b0, 32'd50, 32'd5, 5'd15, 32'd10, 1'b0};
        drive_op(v);
        accept_op("rst_wait");
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0; #1;
        sb_q.delete();
        expect_eq("rst_wait_req_vld", 64'(div_req_vld), 64'd0);
        expect_eq("rst_wait_wb_vld",  64'(wb_vld), 64'd0);
        expect_eq("rst_wait_wb_res",  64'(wb_res), 64'd0);
        expect_eq("rst_wait_wb_rd",   64'(wb_rd), 64'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; #1;
        expect_eq("rst_wait_exu_rdy", 64'(exu_rdy), 64'd1);
        @(posedge clk); #1;

        // flush 3 cycles after issue -> drain, held op refused until response
        v = '{1'b0, 1'b0, 32'd100, 32'd7, 5'd16, 32'd14, 1'b0};
        drive_op(v);
        accept_op("drain");
        expect_eq("drain_issue", 64'(div_req_vld), 64'd1);
        @(posedge clk);
        repeat (3) @(posedge clk); #1;
        exu_flush = 1'b1; #1;
        expect_eq("drain_flush_wb_vld", 64'(wb_vld), 64'd0);
        @(posedge clk); #1;
        exu_flush = 1'b0;
        v = '{1'b0, 1'b0, 32'd9, 32'd3, 5'd17, 32'd3, 1'b0};
        drive_op(v); #1;
        n = 0; saw_wb = 1'b0;
        while (!exu_rdy && n < 200) begin
            if (wb_vld) saw_wb = 1'b1;
            @(posedge clk); #1; n++;
        end
        expect_eq("drain_refused_cycles", 64'(n > 20), 64'd1);
        expect_eq("drain_div_idle", 64'(div_busy), 64'd0);
        expect_eq("drain_no_wb", 64'(saw_wb), 64'd0);
        accept_op("drain_next");
        sb_q.push_back({v.rd, v.res});
        wait_wb("drain_next", lat);
        pop_check("drain_next");
        @(posedge clk); #1;

        // drained 100/7 must not have been cached: this one goes to the divider
        v = '{1'b0, 1'b0, 32'd100, 32'd7, 5'd18, 32'd14, 1'b0};
        run_vec("post_drain", v);

        expect_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
